// File: rtl/rob_ring.sv
// ---------------------------------------------------------------------------
// rob_ring -- circular reorder buffer
//
// Entries are allocated in program order at the tail. Results arrive out of
// order on two writeback ports: wb0 (ALU) and wb1 (load/store). Completed
// entries retire strictly in order from the head onto the registered commit
// bus, at most one per cycle.
//
// Optional feature macro: ROB_FLUSH_EN
//   When defined, a flush input exists. A flush empties the buffer and takes
//   priority over allocation, writeback and commit in the same cycle. When
//   undefined, the port and its logic are absent.
//
// Ports
//   clk, rst            rising-edge clock; asynchronous active-high reset
//   alloc_valid/name    allocation request and destination register name
//   alloc_ready         space available (registered count != DEPTH)
//   alloc_tag           tag that the next allocation receives (tail pointer)
//   wb0_valid/tag/data  ALU writeback; wins over wb1 on a tag collision
//   wb1_valid/tag/data  load/store writeback
//   flush               discard all entries (ROB_FLUSH_EN builds only)
//   commit_valid        registered one-cycle pulse per retired entry
//   commit_name/tag/data registered payload of the retired entry; held
//                       while no commit fires
//   count               registered occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module rob_ring #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int NAME_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [NAME_W-1:0] alloc_name,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              wb0_valid,
    input  logic [TAG_W-1:0]  wb0_tag,
    input  logic [DATA_W-1:0] wb0_data,
    input  logic              wb1_valid,
    input  logic [TAG_W-1:0]  wb1_tag,
    input  logic [DATA_W-1:0] wb1_data,
`ifdef ROB_FLUSH_EN
    input  logic              flush,
`endif
    output logic              commit_valid,
    output logic [NAME_W-1:0] commit_name,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [DATA_W-1:0] commit_data,
    output logic [TAG_W:0]    count
);

    localparam logic [TAG_W:0] L_FULL = (TAG_W+1)'(DEPTH);

    // Per-entry control state (reset) and payload (not reset).
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_ready;
    logic [NAME_W-1:0] r_name [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;

    logic w_flush;
    logic w_alloc_fire;
    logic w_commit_fire;
    logic w_wb0_fire;
    logic w_wb1_fire;

`ifdef ROB_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // Ready is taken from the registered count, so a full buffer refuses
    // allocation even in a cycle where the head retires.
    assign alloc_ready = (r_count != L_FULL);
    assign alloc_tag   = r_tail;
    assign count       = r_count;

    // Every event is suppressed by a flush in the same cycle.
    assign w_alloc_fire  = alloc_valid && alloc_ready && !w_flush;
    assign w_commit_fire = r_valid[r_head] && r_ready[r_head] && !w_flush;
    assign w_wb0_fire    = wb0_valid && r_valid[wb0_tag] && !w_flush;
    assign w_wb1_fire    = wb1_valid && r_valid[wb1_tag] && !w_flush;

    // Valid/ready bits. A tag only becomes visible after allocation, so the
    // allocation and writeback indices never coincide. Commit is applied last
    // so a late writeback to the retiring head cannot leave it ready.
    // NOTE: sequential state uses non-blocking assignments so every process
    // sees the pre-edge values; the last assignment in program order wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_ready <= '0;
        end else if (w_flush) begin
            r_valid <= '0;
            r_ready <= '0;
        end else begin
            if (w_alloc_fire) begin
                r_valid[r_tail] <= 1'b1;
                r_ready[r_tail] <= 1'b0;
            end
            if (w_wb1_fire) r_ready[wb1_tag] <= 1'b1;
            if (w_wb0_fire) r_ready[wb0_tag] <= 1'b1;
            if (w_commit_fire) begin
                r_valid[r_head] <= 1'b0;
                r_ready[r_head] <= 1'b0;
            end
        end
    end

    // Payload storage.
    // NOTE: the name/data arrays are deliberately not reset; they are only
    // observed through entries whose valid bit is set, which reset clears.
    // wb0 is written after wb1 so it wins a same-tag collision.
    always_ff @(posedge clk) begin
        if (w_alloc_fire) r_name[r_tail] <= alloc_name;
        if (w_wb1_fire)   r_data[wb1_tag] <= wb1_data;
        if (w_wb0_fire)   r_data[wb0_tag] <= wb0_data;
    end

    // Pointers and occupancy. Pointers are TAG_W bits wide with DEPTH a power
    // of two, so DEPTH-1 wraps to 0 naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc_fire)  r_tail <= r_tail + TAG_W'(1);
            if (w_commit_fire) r_head <= r_head + TAG_W'(1);
            r_count <= r_count + (TAG_W+1)'(w_alloc_fire)
                               - (TAG_W+1)'(w_commit_fire);
        end
    end

    // Registered commit bus. Payload holds its last value between commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_valid <= 1'b0;
            commit_name  <= '0;
            commit_tag   <= '0;
            commit_data  <= '0;
        end else begin
            commit_valid <= w_commit_fire;
            if (w_commit_fire) begin
                commit_name <= r_name[r_head];
                commit_tag  <= r_head;
                commit_data <= r_data[r_head];
            end
        end
    end

endmodule

// File: tb/tb_rob_ring.sv
// ---------------------------------------------------------------------------
// tb_rob_ring -- directed self-checking bench for rob_ring (DEPTH=16).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// The flush scenario is compiled only when ROB_FLUSH_EN is defined.
// ---------------------------------------------------------------------------
module tb_rob_ring;

    localparam int DEPTH  = 16;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;
    localparam int NAME_W = 5;

    logic              clk;
    logic              rst;
    logic              alloc_valid;
    logic [NAME_W-1:0] alloc_name;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              wb0_valid;
    logic [TAG_W-1:0]  wb0_tag;
    logic [DATA_W-1:0] wb0_data;
    logic              wb1_valid;
    logic [TAG_W-1:0]  wb1_tag;
    logic [DATA_W-1:0] wb1_data;
`ifdef ROB_FLUSH_EN
    logic              flush;
`endif
    logic              commit_valid;
    logic [NAME_W-1:0] commit_name;
    logic [TAG_W-1:0]  commit_tag;
    logic [DATA_W-1:0] commit_data;
    logic [TAG_W:0]    count;

    int errors = 0;
    int checks = 0;

    rob_ring #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .DATA_W(DATA_W),
        .NAME_W(NAME_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_name  (alloc_name),
        .alloc_ready (alloc_ready),
        .alloc_tag   (alloc_tag),
        .wb0_valid   (wb0_valid),
        .wb0_tag     (wb0_tag),
        .wb0_data    (wb0_data),
        .wb1_valid   (wb1_valid),
        .wb1_tag     (wb1_tag),
        .wb1_data    (wb1_data),
`ifdef ROB_FLUSH_EN
        .flush       (flush),
`endif
        .commit_valid(commit_valid),
        .commit_name (commit_name),
        .commit_tag  (commit_tag),
        .commit_data (commit_data),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect a commit pulse with the given payload.
    task automatic expect_commit(input string tag, input int t, input int nm, input int d);
        check({tag, ".cv"},   64'(commit_valid), 64'd1);
        check({tag, ".tag"},  64'(commit_tag),   64'(t));
        check({tag, ".name"}, 64'(commit_name),  64'(nm));
        check({tag, ".data"}, 64'(commit_data),  64'(d));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        alloc_valid = 1'b0;
        alloc_name  = '0;
        wb0_valid   = 1'b0;
        wb0_tag     = '0;
        wb0_data    = '0;
        wb1_valid   = 1'b0;
        wb1_tag     = '0;
        wb1_data    = '0;
`ifdef ROB_FLUSH_EN
        flush       = 1'b0;
`endif
        #12;
        rst = 1'b0;

        // Reset state
        check("rst.cv",    64'(commit_valid), 64'd0);
        check("rst.count", 64'(count),        64'd0);
        check("rst.ready", 64'(alloc_ready),  64'd1);
        check("rst.atag",  64'(alloc_tag),    64'd0);
        check("rst.cdata", 64'(commit_data),  64'd0);

        // 1. In-order fill and drain
        for (int i = 0; i < 16; i++) begin
            check("fill.atag", 64'(alloc_tag), 64'(i));
            alloc_valid = 1'b1;
            alloc_name  = NAME_W'(i + 1);
            step();
        end
        alloc_valid = 1'b0;
        check("fill.count", 64'(count),       64'd16);
        check("fill.ready", 64'(alloc_ready), 64'd0);
        check("fill.atag",  64'(alloc_tag),   64'd0);
        for (int t = 0; t < 16; t++) begin
            wb0_valid = 1'b1;
            wb0_tag   = TAG_W'(t);
            wb0_data  = DATA_W'(32'h100 + t);
            step();
            if (t == 0) begin
                check("drain.nobypass", 64'(commit_valid), 64'd0);
            end else begin
                expect_commit("drain", t - 1, t, 32'h100 + t - 1);
                check("drain.count", 64'(count), 64'(16 - t));
            end
        end
        wb0_valid = 1'b0;
        step();
        expect_commit("drain.last", 15, 16, 32'h10F);
        check("drain.count0", 64'(count), 64'd0);
        step();
        check("drain.idle.cv",  64'(commit_valid), 64'd0);
        check("drain.hold.tag", 64'(commit_tag),   64'd15);

        // 2. Out-of-order completion: tags 0,1,2 (names 5,6,7)
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1;
            alloc_name  = NAME_W'(5 + i);
            step();
        end
        alloc_valid = 1'b0;
        wb0_valid = 1'b1; wb0_tag = 4'd2; wb0_data = 32'h22;
        step();
        check("ooo.wait2", 64'(commit_valid), 64'd0);
        wb0_tag = 4'd1; wb0_data = 32'h11;
        step();
        check("ooo.wait1", 64'(commit_valid), 64'd0);
        wb0_tag = 4'd0; wb0_data = 32'h33;
        step();
        check("ooo.wait0", 64'(commit_valid), 64'd0);
        wb0_valid = 1'b0;
        step();
        expect_commit("ooo.c0", 0, 5, 32'h33);
        step();
        expect_commit("ooo.c1", 1, 6, 32'h11);
        step();
        expect_commit("ooo.c2", 2, 7, 32'h22);
        check("ooo.count", 64'(count), 64'd0);
        step();
        check("ooo.idle", 64'(commit_valid), 64'd0);

        // 3. Dual-port collision on tag 3, then a dropped writeback
        alloc_valid = 1'b1; alloc_name = 5'd9;
        step();
        alloc_valid = 1'b0;
        check("coll.atag", 64'(alloc_tag), 64'd4);
        wb0_valid = 1'b1; wb0_tag = 4'd3; wb0_data = 32'hAAAA;
        wb1_valid = 1'b1; wb1_tag = 4'd3; wb1_data = 32'h5555;
        step();
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        check("coll.nobypass", 64'(commit_valid), 64'd0);
        step();
        expect_commit("coll", 3, 9, 32'hAAAA);
        // tag 5 is not allocated yet: this write must be dropped
        wb1_valid = 1'b1; wb1_tag = 4'd5; wb1_data = 32'hDEAD;
        step();
        wb1_valid = 1'b0;
        check("drop.count", 64'(count), 64'd0);
        alloc_valid = 1'b1; alloc_name = 5'd1;   // tag 4
        step();
        alloc_name = 5'd2;                       // tag 5
        step();
        alloc_valid = 1'b0;
        wb0_valid = 1'b1; wb0_tag = 4'd4; wb0_data = 32'h44;
        step();
        wb0_valid = 1'b0;
        step();
        expect_commit("drop.c4", 4, 1, 32'h44);
        step();
        check("drop.notready", 64'(commit_valid), 64'd0);
        check("drop.count1",   64'(count),        64'd1);
        wb1_valid = 1'b1; wb1_tag = 4'd5; wb1_data = 32'h55;
        step();
        wb1_valid = 1'b0;
        step();
        expect_commit("wb1.c5", 5, 2, 32'h55);

        // 4. Full with simultaneous commit (restart from reset so head=0)
        rst = 1'b1;
        #2;
        check("rst4.count", 64'(count), 64'd0);
        rst = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            alloc_valid = 1'b1;
            alloc_name  = NAME_W'(i + 1);
            step();
        end
        alloc_valid = 1'b0;
        check("full.count", 64'(count),       64'd16);
        check("full.ready", 64'(alloc_ready), 64'd0);
        wb0_valid = 1'b1; wb0_tag = 4'd0; wb0_data = 32'hC0;
        step();
        wb0_valid = 1'b0;
        check("full.nobypass", 64'(commit_valid), 64'd0);
        alloc_valid = 1'b1; alloc_name = 5'd30;
        step();
        expect_commit("full.c0", 0, 1, 32'hC0);
        check("full.refused.count", 64'(count),       64'd15);
        check("full.refused.atag",  64'(alloc_tag),   64'd0);
        check("full.ready15",       64'(alloc_ready), 64'd1);
        step();
        alloc_valid = 1'b0;
        check("full.realloc.count", 64'(count),        64'd16);
        check("full.realloc.atag",  64'(alloc_tag),    64'd1);
        check("full.realloc.cv",    64'(commit_valid), 64'd0);

        // 6. Asynchronous reset during a commit burst (head=1, tags 1..15)
        wb0_valid = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            wb0_tag  = TAG_W'(t);
            wb0_data = DATA_W'(32'h200 + t);
            step();
            if (t > 1) expect_commit("burst", t - 1, t, 32'h200 + t - 1);
        end
        #2;
        rst = 1'b1;
        #1;
        check("arst.cv",    64'(commit_valid), 64'd0);
        check("arst.count", 64'(count),        64'd0);
        check("arst.tag",   64'(commit_tag),   64'd0);
        check("arst.name",  64'(commit_name),  64'd0);
        check("arst.data",  64'(commit_data),  64'd0);
        check("arst.ready", 64'(alloc_ready),  64'd1);
        check("arst.atag",  64'(alloc_tag),    64'd0);
        wb0_valid = 1'b0;
        rst = 1'b0;
        step();
        check("arst.after.cv",    64'(commit_valid), 64'd0);
        check("arst.after.count", 64'(count),        64'd0);

`ifdef ROB_FLUSH_EN
        // 5. Flush with 5 entries, 2 ready, plus alloc and writeback
        for (int i = 0; i < 5; i++) begin
            alloc_valid = 1'b1;
            alloc_name  = NAME_W'(i + 1);
            step();
        end
        alloc_valid = 1'b0;
        wb0_valid = 1'b1; wb0_tag = 4'd1; wb0_data = 32'hF1;
        wb1_valid = 1'b1; wb1_tag = 4'd2; wb1_data = 32'hF2;
        step();
        wb1_valid = 1'b0;
        check("flush.pre.count", 64'(count), 64'd5);
        flush = 1'b1;
        alloc_valid = 1'b1; alloc_name = 5'd7;
        wb0_tag = 4'd0; wb0_data = 32'hF0;
        step();
        flush = 1'b0; alloc_valid = 1'b0; wb0_valid = 1'b0;
        check("flush.count", 64'(count),        64'd0);
        check("flush.cv",    64'(commit_valid), 64'd0);
        check("flush.atag",  64'(alloc_tag),    64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush.nocommit", 64'(commit_valid), 64'd0);
        end
        alloc_valid = 1'b1; alloc_name = 5'd8;
        step();
        alloc_valid = 1'b0;
        check("flush.realloc.atag",  64'(alloc_tag), 64'd1);
        check("flush.realloc.count", 64'(count),     64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rob_ring.md
# rob_ring

Parametrised circular reorder buffer for the out-of-order core. Entries are allocated in program order at issue. Results arrive out of order on two writeback ports: ALU and load/store. Completed entries retire strictly in order onto the commit/CDB bus, at most one per cycle, with an optional pipeline flush.

## Interface

Parameters:
- DEPTH, 16, number of entries; power of two, at least 2
- TAG_W, 4, entry index width; equals log2(DEPTH)
- DATA_W, 32, result width
- NAME_W, 5, destination register name width; name 0 is the free name

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- alloc_valid  in  1  allocate one entry this cycle
- alloc_name  in  NAME_W  destination name of the allocated entry
- alloc_ready  out  1  space available; equals (count != DEPTH)
- alloc_tag  out  TAG_W  tag given to the next allocation; equals tail
- wb0_valid  in  1  ALU writeback strobe
- wb0_tag  in  TAG_W  ALU writeback tag
- wb0_data  in  DATA_W  ALU writeback data
- wb1_valid  in  1  LS writeback strobe
- wb1_tag  in  TAG_W  LS writeback tag
- wb1_data  in  DATA_W  LS writeback data
- flush  in  1  discard all entries (only with ROB_FLUSH_EN)
- commit_valid  out  1  registered; one-cycle pulse per retired entry
- commit_name  out  NAME_W  registered; name of the retired entry
- commit_tag  out  TAG_W  registered; tag of the retired entry
- commit_data  out  DATA_W  registered; data of the retired entry
- count  out  TAG_W+1  registered occupancy, 0..DEPTH

## Operation

- Per-entry state: valid, ready, name, data. Pointers: head and tail, each TAG_W bits, wrapping modulo DEPTH. count is kept explicitly, so full (count == DEPTH) and empty (count == 0) are distinguishable when head == tail.
- Allocation fires when alloc_valid && alloc_ready. It sets entry[tail] to valid=1, ready=0, name=alloc_name and increments tail. alloc_valid while full is ignored; no state changes.
- Writeback to port p fires when wbp_valid is high and entry[wbp_tag].valid is set. It sets ready=1 and data=wbp_data. Writeback to an invalid entry is dropped.
- If both ports hit the same tag in one cycle, wb0 wins.
- Commit fires when entry[head].valid && entry[head].ready, as seen in registered state. It drives commit_* from entry[head], pulses commit_valid, clears entry[head].valid and increments head.
- An entry with name 0 still commits. The consumer ignores it.
- count_next = count + alloc_fire - commit_fire. Allocate and commit in the same cycle leave count unchanged.
- alloc_ready is computed from the registered count. A full buffer refuses allocation even in a cycle where it commits.
- Allocation and writeback never target the same entry in one cycle, because the tag only becomes visible after allocation.

## Timing

- Reset values:
  - commit_valid, commit_name, commit_tag, commit_data, count: all 0.
  - head, tail, all valid and ready bits: 0.
  - Consequently alloc_ready=1 and alloc_tag=0.
- Reset mid-operation discards every entry immediately (asynchronous).
- Writeback at edge N sets ready. The earliest commit of that entry is edge N+1, with commit_valid high during cycle N+1. Writeback-to-commit latency is therefore 1 cycle; there is no same-cycle bypass.
- Commit throughput is one entry per cycle while consecutive head entries are ready.
- When no commit fires, commit_valid is 0 and commit_name, commit_tag, commit_data hold their last values.
- Pointer wrap: index DEPTH-1 increments to 0 with no bubble.

## Configuration

- ROB_FLUSH_EN defined:
  - The flush port exists. Flush is sampled at the rising edge and has priority over allocation, writeback and commit in that cycle.
  - It clears all valid and ready bits and sets head=tail=count=0.
  - commit_valid is 0 in the following cycle.
  - Allocation and writeback presented in the flush cycle are discarded.
- ROB_FLUSH_EN undefined: the flush port and its logic are absent. Entries leave only by commit or reset.

## Test plan

1. In-order fill and drain:
   - Stimulus: with DEPTH=16, allocate names 1..16 over 16 cycles.
   - Response: alloc_tag steps 0..15, alloc_ready=0, count=16.
   - Stimulus: write back tags 0..15 in order on wb0 with data 0x100+tag.
   - Response: 16 consecutive commits, tags 0..15, data 0x100..0x10F, ending with count=0.
2. Out-of-order completion:
   - Stimulus: allocate tags 0,1,2, then write back tag 2, then 1, then 0.
   - Response: no commit until tag 0 is written. Commits then follow on three consecutive cycles in order 0,1,2.
3. Dual-port collision:
   - Stimulus: write back tag 3 on wb0 with data 0xAAAA and on wb1 with data 0x5555 in the same cycle.
   - Response: tag 3 commits with data 0xAAAA.
   - Stimulus: write back to a tag that was never allocated.
   - Response: no state change.
4. Full with simultaneous commit:
   - Stimulus: at count=16, with head ready, assert alloc_valid.
   - Response: allocation refused, the commit occurs, and count becomes 15. The next alloc gets tag 0 (wrapped) and count returns to 16.
5. Flush (ROB_FLUSH_EN):
   - Stimulus: with 5 entries, 2 of them ready, assert flush together with alloc_valid and a writeback.
   - Response: the next cycle shows count=0, commit_valid=0 and alloc_tag=0, and no later commit of the flushed tags.
6. Asynchronous reset mid-drain:
   - Stimulus: assert rst between clock edges during a commit burst.
   - Response: all outputs go to 0 immediately and alloc_ready=1.
